network_bf_out: RTL and testbench

Write-back routing network for the radix-2, 4-BFU NTT datapath: returns the eight butterfly results (x0,y0..x3,y3) to the eight memory banks. Per-bank 3-bit source selects, the common write address and a valid strobe are issued with the read-side control. They are delayed internally to line up with the butterfly pipeline. A bank-permutation check blocks colliding write beats.

---
 rtl/ntt_net_pkg.sv | 35 +++
 rtl/network_bf_out_if.sv | 58 +++++
 rtl/network_bf_out_ctrl_delay.sv | 30 +++
 rtl/network_bf_out.sv | 106 ++++++++++
 tb/tb_network_bf_out.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_net_pkg.sv
// Shared definitions for the NTT read-side and write-back bank routing networks.
// Source encoding is common to both networks, so one select value means the same lane everywhere.
package ntt_net_pkg;

   localparam int SEL_W    = 3;
   localparam int NUM_BANK = 8;

   typedef enum logic [SEL_W-1:0] {
      SRC_X0 = 3'd0,
      SRC_Y0 = 3'd1,
      SRC_X1 = 3'd2,
      SRC_Y1 = 3'd3,
      SRC_X2 = 3'd4,
      SRC_Y2 = 3'd5,
      SRC_X3 = 3'd6,
      SRC_Y3 = 3'd7
   } src_e;

   typedef logic [NUM_BANK*SEL_W-1:0] sel_vec_t;

   // True when any two bank selects name the same source, i.e. the beat is not a permutation.
   function automatic logic sel_collision(input sel_vec_t sels);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_BANK - 1; i++) begin
         for (int j = i + 1; j < NUM_BANK; j++) begin
            if (sels[i*SEL_W +: SEL_W] == sels[j*SEL_W +: SEL_W]) begin
               hit = 1'b1;
            end
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/network_bf_out_if.sv
// Bundle of control, butterfly data and bank write signals for the write-back network.
// The master side issues control/data; the slave side (the network) drives the bank writes.
interface network_bf_out_if #(
   parameter int data_width = 14,
   parameter int addr_width = 6
);
   import ntt_net_pkg::*;

   logic [SEL_W-1:0]      sel_b_0;
   logic [SEL_W-1:0]      sel_b_1;
   logic [SEL_W-1:0]      sel_b_2;
   logic [SEL_W-1:0]      sel_b_3;
   logic [SEL_W-1:0]      sel_b_4;
   logic [SEL_W-1:0]      sel_b_5;
   logic [SEL_W-1:0]      sel_b_6;
   logic [SEL_W-1:0]      sel_b_7;
   logic [addr_width-1:0] addr_in;
   logic                  vld_in;
   logic [data_width-1:0] x0;
   logic [data_width-1:0] y0;
   logic [data_width-1:0] x1;
   logic [data_width-1:0] y1;
   logic [data_width-1:0] x2;
   logic [data_width-1:0] y2;
   logic [data_width-1:0] x3;
   logic [data_width-1:0] y3;
   logic                  err_clr;
   logic [data_width-1:0] d0;
   logic [data_width-1:0] d1;
   logic [data_width-1:0] d2;
   logic [data_width-1:0] d3;
   logic [data_width-1:0] d4;
   logic [data_width-1:0] d5;
   logic [data_width-1:0] d6;
   logic [data_width-1:0] d7;
   logic [NUM_BANK-1:0]   wen;
   logic [addr_width-1:0] waddr;
   logic                  perm_err;

   modport master (
      output sel_b_0, sel_b_1, sel_b_2, sel_b_3, sel_b_4, sel_b_5, sel_b_6, sel_b_7,
      output addr_in, vld_in,
      output x0, y0, x1, y1, x2, y2, x3, y3,
      output err_clr,
      input  d0, d1, d2, d3, d4, d5, d6, d7,
      input  wen, waddr, perm_err
   );

   modport slave (
      input  sel_b_0, sel_b_1, sel_b_2, sel_b_3, sel_b_4, sel_b_5, sel_b_6, sel_b_7,
      input  addr_in, vld_in,
      input  x0, y0, x1, y1, x2, y2, x3, y3,
      input  err_clr,
      output d0, d1, d2, d3, d4, d5, d6, d7,
      output wen, waddr, perm_err
   );

endinterface

// File: rtl/network_bf_out_ctrl_delay.sv
// Fixed-depth shift register that ages the control bundle alongside the butterfly pipeline.
// A synchronous clear empties every stage so no pre-reset beat can reach the tail.
module ctrl_delay #(
   parameter int width = 1,
   parameter int depth = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout
);

   logic [width-1:0] stage [depth];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < depth; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= din;
         for (int i = 1; i < depth; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[depth-1];

endmodule

// File: rtl/network_bf_out.sv
// Write-back routing network: aligns control with the butterfly outputs, routes x/y lanes to
// the eight banks and blocks any beat whose selects are not a permutation.
module network_bf_out
   import ntt_net_pkg::*;
#(
   parameter int data_width = 14,
   parameter int addr_width = 6,
   parameter int BF_LAT     = 3
) (
   input  logic            clk,
   input  logic            rst,
   network_bf_out_if.slave bus
);

   localparam int SELS_W = NUM_BANK * SEL_W;
   localparam int CTRL_W = SELS_W + addr_width + 1;

   logic [CTRL_W-1:0]     ctrl_head;
   logic [CTRL_W-1:0]     ctrl_tail;
   sel_vec_t              tail_sels;
   logic [addr_width-1:0] tail_addr;
   logic                  tail_vld;
   logic                  collision;

   logic [data_width-1:0] src    [NUM_BANK];
   logic [data_width-1:0] routed [NUM_BANK];
   logic [data_width-1:0] d_q    [NUM_BANK];
   logic [NUM_BANK-1:0]   wen_q;
   logic [addr_width-1:0] waddr_q;
   logic                  perm_err_q;

   assign ctrl_head = {bus.sel_b_7, bus.sel_b_6, bus.sel_b_5, bus.sel_b_4,
                       bus.sel_b_3, bus.sel_b_2, bus.sel_b_1, bus.sel_b_0,
                       bus.addr_in, bus.vld_in};

   ctrl_delay #(
      .width (CTRL_W),
      .depth (BF_LAT)
   ) u_ctrl_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (ctrl_head),
      .dout (ctrl_tail)
   );

   assign tail_sels = ctrl_tail[CTRL_W-1 -: SELS_W];
   assign tail_addr = ctrl_tail[addr_width:1];
   assign tail_vld  = ctrl_tail[0];

   assign src[SRC_X0] = bus.x0;
   assign src[SRC_Y0] = bus.y0;
   assign src[SRC_X1] = bus.x1;
   assign src[SRC_Y1] = bus.y1;
   assign src[SRC_X2] = bus.x2;
   assign src[SRC_Y2] = bus.y2;
   assign src[SRC_X3] = bus.x3;
   assign src[SRC_Y3] = bus.y3;

   // Every bank has a full 8:1 mux; all eight select codes are legal so each output is always defined.
   always_comb begin
      routed = '{default: '0};
      for (int k = 0; k < NUM_BANK; k++) begin
         routed[k] = src[tail_sels[k*SEL_W +: SEL_W]];
      end
   end

   assign collision = tail_vld & sel_collision(tail_sels);

   // Colliding beats still refresh d/waddr but never raise wen; a collision beats err_clr.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NUM_BANK; k++) begin
            d_q[k] <= '0;
         end
         wen_q      <= '0;
         waddr_q    <= '0;
         perm_err_q <= 1'b0;
      end else begin
         if (tail_vld) begin
            for (int k = 0; k < NUM_BANK; k++) begin
               d_q[k] <= routed[k];
            end
            waddr_q <= tail_addr;
         end
         wen_q <= (tail_vld && !collision) ? '1 : '0;
         if (collision) begin
            perm_err_q <= 1'b1;
         end else if (bus.err_clr) begin
            perm_err_q <= 1'b0;
         end
      end
   end

   assign bus.d0       = d_q[0];
   assign bus.d1       = d_q[1];
   assign bus.d2       = d_q[2];
   assign bus.d3       = d_q[3];
   assign bus.d4       = d_q[4];
   assign bus.d5       = d_q[5];
   assign bus.d6       = d_q[6];
   assign bus.d7       = d_q[7];
   assign bus.wen      = wen_q;
   assign bus.waddr    = waddr_q;
   assign bus.perm_err = perm_err_q;

endmodule

// File: tb/tb_network_bf_out.sv
// Scoreboard bench for network_bf_out: stimulus predicts each bank write from the source
// table and pushes it; an independent monitor compares outputs every cycle.
module tb_network_bf_out;
   import ntt_net_pkg::*;

   localparam int DW     = 14;
   localparam int AW     = 6;
   localparam int BF_LAT = 3;
   localparam int DV_W   = NUM_BANK * DW;

   typedef logic [DV_W-1:0] dvec_t;

   typedef struct {
      int            out_cycle;
      bit            collide;
      logic [AW-1:0] addr;
      dvec_t         d;
   } exp_t;

   logic  clk      = 1'b0;
   logic  rst      = 1'b0;
   int    edge_cnt = 0;
   logic  rst_seen = 1'b0;
   logic  clr_seen = 1'b0;
   int    n_checks = 0;
   int    n_fail   = 0;
   exp_t  exp_q [$];
   dvec_t data_sched [int];

   network_bf_out_if #(.data_width(DW), .addr_width(AW)) bus ();

   network_bf_out #(
      .data_width (DW),
      .addr_width (AW),
      .BF_LAT     (BF_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Record what the DUT sampled at each rising edge; inputs change 1 time unit later.
   initial begin
      forever begin
         @(posedge clk);
         edge_cnt = edge_cnt + 1;
         rst_seen = rst;
         clr_seen = bus.err_clr;
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, expv);
      end
   endtask

   function automatic dvec_t rand_data();
      dvec_t r;
      for (int i = 0; i < NUM_BANK; i++) begin
         r[i*DW +: DW] = DW'($urandom);
      end
      return r;
   endfunction

   function automatic sel_vec_t rand_sels();
      return sel_vec_t'($urandom);
   endfunction

   function automatic sel_vec_t shuffle_sels();
      int       p [NUM_BANK];
      int       j;
      int       t;
      sel_vec_t s;
      for (int i = 0; i < NUM_BANK; i++) p[i] = i;
      for (int i = NUM_BANK - 1; i > 0; i--) begin
         j    = int'($urandom_range(i, 0));
         t    = p[i];
         p[i] = p[j];
         p[j] = t;
      end
      for (int k = 0; k < NUM_BANK; k++) s[k*SEL_W +: SEL_W] = SEL_W'(p[k]);
      return s;
   endfunction

   function automatic sel_vec_t map_sels(input int mode);
      sel_vec_t s;
      for (int k = 0; k < NUM_BANK; k++) begin
         if (mode == 0) s[k*SEL_W +: SEL_W] = SEL_W'(k);
         else           s[k*SEL_W +: SEL_W] = SEL_W'(NUM_BANK - 1 - k);
      end
      return s;
   endfunction

   // Drives one cycle; a valid beat out of reset gets its data scheduled and its write predicted.
   task automatic applyStimulus(input logic v, input sel_vec_t sels, input logic [AW-1:0] addr,
                                input dvec_t data, input logic clr, input logic rst_v);
      int    target;
      int    s;
      exp_t  e;
      bit    seen [NUM_BANK];
      dvec_t now_d;
      target      = edge_cnt + 1;
      rst         = rst_v;
      bus.vld_in  = v;
      bus.addr_in = addr;
      bus.err_clr = clr;
      bus.sel_b_0 = sels[0*SEL_W +: SEL_W];
      bus.sel_b_1 = sels[1*SEL_W +: SEL_W];
      bus.sel_b_2 = sels[2*SEL_W +: SEL_W];
      bus.sel_b_3 = sels[3*SEL_W +: SEL_W];
      bus.sel_b_4 = sels[4*SEL_W +: SEL_W];
      bus.sel_b_5 = sels[5*SEL_W +: SEL_W];
      bus.sel_b_6 = sels[6*SEL_W +: SEL_W];
      bus.sel_b_7 = sels[7*SEL_W +: SEL_W];
      if (data_sched.exists(target)) begin
         now_d = data_sched[target];
         data_sched.delete(target);
      end else begin
         now_d = rand_data();
      end
      bus.x0 = now_d[0*DW +: DW];
      bus.y0 = now_d[1*DW +: DW];
      bus.x1 = now_d[2*DW +: DW];
      bus.y1 = now_d[3*DW +: DW];
      bus.x2 = now_d[4*DW +: DW];
      bus.y2 = now_d[5*DW +: DW];
      bus.x3 = now_d[6*DW +: DW];
      bus.y3 = now_d[7*DW +: DW];
      if (v && rst_v) begin
         data_sched[target + BF_LAT] = data;
         e.out_cycle = target + BF_LAT;
         e.collide   = 1'b0;
         e.addr      = addr;
         e.d         = '0;
         for (int i = 0; i < NUM_BANK; i++) seen[i] = 1'b0;
         for (int k = 0; k < NUM_BANK; k++) begin
            s = int'(sels[k*SEL_W +: SEL_W]);
            if (seen[s]) e.collide = 1'b1;
            seen[s] = 1'b1;
            e.d[k*DW +: DW] = data[s*DW +: DW];
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, rand_sels(), AW'($urandom), '0, 1'b0, 1'b1);
      end
   endtask

   // Monitor: reference model of the bank outputs, advanced by popping predicted writes.
   initial begin : monitor
      exp_t          e;
      dvec_t         model_d;
      logic [AW-1:0] model_addr;
      logic          model_err;
      logic [7:0]    exp_wen;
      dvec_t         act_d;
      model_d    = '0;
      model_addr = '0;
      model_err  = 1'b0;
      forever begin
         @(negedge clk);
         act_d   = {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
         exp_wen = 8'h00;
         if (!rst_seen) begin
            while (exp_q.size() > 0 && exp_q[0].out_cycle < edge_cnt + BF_LAT) begin
               void'(exp_q.pop_front());
            end
            model_d    = '0;
            model_addr = '0;
            model_err  = 1'b0;
         end else if (exp_q.size() > 0 && exp_q[0].out_cycle == edge_cnt) begin
            e          = exp_q.pop_front();
            model_d    = e.d;
            model_addr = e.addr;
            if (e.collide) begin
               model_err = 1'b1;
            end else begin
               exp_wen = 8'hFF;
               if (clr_seen) model_err = 1'b0;
            end
         end else if (clr_seen) begin
            model_err = 1'b0;
         end
         checkOutput("wen",      128'(bus.wen),      128'(exp_wen));
         checkOutput("perm_err", 128'(bus.perm_err), 128'(model_err));
         checkOutput("waddr",    128'(bus.waddr),    128'(model_addr));
         checkOutput("d",        128'(act_d),        128'(model_d));
      end
   end

   initial begin : stimulus
      dvec_t    data;
      sel_vec_t col;
      bus.vld_in  = 1'b0;
      bus.addr_in = '0;
      bus.err_clr = 1'b0;
      bus.sel_b_0 = '0; bus.sel_b_1 = '0; bus.sel_b_2 = '0; bus.sel_b_3 = '0;
      bus.sel_b_4 = '0; bus.sel_b_5 = '0; bus.sel_b_6 = '0; bus.sel_b_7 = '0;
      bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
      bus.x2 = '0; bus.y2 = '0; bus.x3 = '0; bus.y3 = '0;

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);

      $display("[TB] identity beat");
      for (int i = 0; i < NUM_BANK; i++) data[i*DW +: DW] = DW'(i + 1);
      applyStimulus(1'b1, map_sels(0), AW'(5), data, 1'b0, 1'b1);
      idle(BF_LAT + 2);

      $display("[TB] reversed permutation, back-to-back");
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < NUM_BANK; i++) data[i*DW +: DW] = DW'(b * NUM_BANK + i + 1);
         applyStimulus(1'b1, map_sels(1), AW'(b + 8), data, 1'b0, 1'b1);
      end
      idle(BF_LAT + 2);

      $display("[TB] collision, recovery, clear");
      col = {3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0, 3'd3, 3'd3};
      applyStimulus(1'b1, col, AW'(20), rand_data(), 1'b0, 1'b1);
      applyStimulus(1'b1, map_sels(0), AW'(21), rand_data(), 1'b0, 1'b1);
      idle(BF_LAT + 3);
      applyStimulus(1'b0, rand_sels(), '0, '0, 1'b1, 1'b1);
      idle(2);

      $display("[TB] collision coincident with clear");
      applyStimulus(1'b1, col, AW'(22), rand_data(), 1'b0, 1'b1);
      idle(BF_LAT - 1);
      applyStimulus(1'b0, rand_sels(), '0, '0, 1'b1, 1'b1);
      idle(2);
      applyStimulus(1'b0, rand_sels(), '0, '0, 1'b1, 1'b1);
      applyStimulus(1'b0, col, AW'(23), rand_data(), 1'b0, 1'b1);
      idle(BF_LAT + 2);

      $display("[TB] reset mid-flight");
      applyStimulus(1'b1, map_sels(0), AW'(30), rand_data(), 1'b0, 1'b1);
      applyStimulus(1'b1, map_sels(1), AW'(31), rand_data(), 1'b0, 1'b1);
      applyStimulus(1'b0, rand_sels(), '0, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, shuffle_sels(), AW'(32), rand_data(), 1'b0, 1'b1);
      idle(BF_LAT + 2);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(3, 0) != 0,
                       ($urandom_range(4, 0) == 0) ? rand_sels() : shuffle_sels(),
                       AW'($urandom), rand_data(),
                       $urandom_range(9, 0) == 0,
                       $urandom_range(59, 0) != 0);
      end
      idle(BF_LAT + 3);
      checkOutput("drain", 128'(exp_q.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
